// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu multiply/popcount service:
// register map, controller states and status bit positions.
package gpioemu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_A1     = 16'h037F;
    localparam logic [ADDR_W-1:0] ADDR_A2     = 16'h0388;
    localparam logic [ADDR_W-1:0] ADDR_PROD_L = 16'h0390;
    localparam logic [ADDR_W-1:0] ADDR_PROD_H = 16'h0394;
    localparam logic [ADDR_W-1:0] ADDR_ONES   = 16'h0398;
    localparam logic [ADDR_W-1:0] ADDR_START  = 16'h03A0;

    localparam int unsigned STAT_VALID = 0;
    localparam int unsigned STAT_READY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gpioemu_shift_mul.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per cycle,
// bit 0 consumed on the go edge, done pulses once the last bit has been added.
module gpioemu_shift_mul #(
    parameter int unsigned W = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           go,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W);

    logic [PW-1:0] mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (go && !busy_q) begin
            // Operands are captured here; bit 0 is folded in on the same edge
            acc_d    = b[0] ? PW'(a) : '0;
            mcand_d  = PW'(a) << 1;
            mplier_d = b >> 1;
            idx_d    = CW'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            idx_d    = idx_q + CW'(1);
            if (idx_q == CW'(W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/gpioemu_mul_seq.sv
// gpioemu multiply/popcount controller: bus register front end, operation
// sequencer (multiply, popcount, publish), completion counter and GPIO capture.
module gpioemu_mul_seq
    import gpioemu_pkg::*;
#(
    parameter int unsigned OP_W     = 24,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned POP_STEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] saddress,
    input  logic              srd,
    input  logic              swr,
    input  logic [BUS_W-1:0]  sdata_in,
    output logic [BUS_W-1:0]  sdata_out,
    input  logic [BUS_W-1:0]  gpio_in,
    input  logic              gpio_latch,
    output logic [BUS_W-1:0]  gpio_out,
    output logic [BUS_W-1:0]  gpio_in_s_insp
);

    localparam int unsigned PROD_W = 2 * OP_W;
    localparam int unsigned POP_N  = PROD_W / POP_STEP;
    localparam int unsigned PIDX_W = $clog2(POP_N);
    localparam int unsigned ONES_W = $clog2(PROD_W + 1);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a1_q, a1_d;
    logic [OP_W-1:0]     a2_q, a2_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [ONES_W-1:0]   ones_acc_q, ones_acc_d;
    logic [PIDX_W-1:0]   pidx_q, pidx_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    op_count_q, op_count_d;
    logic [BUS_W-1:0]    sdata_out_q, sdata_out_d;
    logic [BUS_W-1:0]    gpio_in_s_q, gpio_in_s_d;

    logic                start_acc;
    logic                mul_busy;
    logic                mul_done;
    logic [PROD_W-1:0]   mul_product;
    logic [BUS_W-1:0]    rdata;
    logic [POP_STEP-1:0] pop_slice;
    logic [ONES_W-1:0]   pop_cnt;
    logic                unused_sdata;

    assign unused_sdata = &{1'b0, sdata_in[BUS_W-1:OP_W]};
    assign start_acc    = swr && (saddress == ADDR_START) && (state_q == IDLE) && !mul_busy;

    gpioemu_shift_mul #(
        .W(OP_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .go      (start_acc),
        .a       (a1_q),
        .b       (a2_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Read mux works on current register values, so a same-cycle write is not seen
    always_comb begin
        rdata = '0;
        case (saddress)
            ADDR_START: begin
                rdata[STAT_READY] = ready_q;
                rdata[STAT_VALID] = valid_q;
            end
            ADDR_PROD_L: rdata = product_q[31:0];
            ADDR_PROD_H: rdata = BUS_W'(product_q[PROD_W-1:32]);
            ADDR_ONES:   rdata = BUS_W'(ones_q);
            default:     rdata = '0;
        endcase
    end

    // Ones in the next POP_STEP product bits
    always_comb begin
        pop_slice = POP_STEP'(mul_product >> (32'(pidx_q) * POP_STEP));
        pop_cnt   = '0;
        for (int i = 0; i < POP_STEP; i++) begin
            pop_cnt = pop_cnt + ONES_W'(pop_slice[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        product_d   = product_q;
        ones_d      = ones_q;
        ones_acc_d  = ones_acc_q;
        pidx_d      = pidx_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        op_count_d  = op_count_q;
        sdata_out_d = sdata_out_q;
        gpio_in_s_d = gpio_in_s_q;

        if (srd) begin
            sdata_out_d = rdata;
        end
        if (swr && (saddress == ADDR_A1)) begin
            a1_d = sdata_in[OP_W-1:0];
        end
        if (swr && (saddress == ADDR_A2)) begin
            a2_d = sdata_in[OP_W-1:0];
        end
        if (gpio_latch) begin
            gpio_in_s_d = gpio_in;
        end

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = MULT;
                    ready_d = 1'b0;
                end
            end
            MULT: begin
                if (mul_done) begin
                    state_d    = COUNT;
                    pidx_d     = '0;
                    ones_acc_d = '0;
                end
            end
            COUNT: begin
                ones_acc_d = ones_acc_q + pop_cnt;
                pidx_d     = pidx_q + PIDX_W'(1);
                if (pidx_q == PIDX_W'(POP_N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                product_d  = mul_product;
                ones_d     = ones_acc_q;
                valid_d    = (mul_product[PROD_W-1:32] == '0);
                op_count_d = op_count_q + CNT_W'(1);
                ready_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a1_q        <= '0;
            a2_q        <= '0;
            product_q   <= '0;
            ones_q      <= '0;
            ones_acc_q  <= '0;
            pidx_q      <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b1;
            op_count_q  <= '0;
            sdata_out_q <= '0;
            gpio_in_s_q <= '0;
        end else begin
            state_q     <= state_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            product_q   <= product_d;
            ones_q      <= ones_d;
            ones_acc_q  <= ones_acc_d;
            pidx_q      <= pidx_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            op_count_q  <= op_count_d;
            sdata_out_q <= sdata_out_d;
            gpio_in_s_q <= gpio_in_s_d;
        end
    end

    assign sdata_out      = sdata_out_q;
    assign gpio_out       = BUS_W'(op_count_q);
    assign gpio_in_s_insp = gpio_in_s_q;

endmodule

// File: tb/tb_gpioemu_mul_seq.sv
// Scoreboard bench for gpioemu_mul_seq: stimulus queues expected read data and
// pin probes, a monitor pops and compares when the DUT presents them.
module tb_gpioemu_mul_seq;

    localparam logic [15:0] A_A1    = 16'h037F;
    localparam logic [15:0] A_A2    = 16'h0388;
    localparam logic [15:0] A_PL    = 16'h0390;
    localparam logic [15:0] A_PH    = 16'h0394;
    localparam logic [15:0] A_ONES  = 16'h0398;
    localparam logic [15:0] A_START = 16'h03A0;

    localparam int K_GPIO = 1;
    localparam int K_INSP = 2;
    localparam int K_TOUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in;
    logic        gpio_latch;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in_s_insp;

    logic sb_rd = 1'b0;
    logic probe = 1'b0;
    logic to_flag = 1'b0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } pr_exp_t;

    rd_exp_t rd_q[$];
    pr_exp_t pr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpioemu_mul_seq dut (
        .clk            (clk),
        .reset          (reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp)
    );

    // Monitor: a scored read or probe at an edge is checked 1ns after it
    always @(posedge clk) begin : monitor
        logic        do_rd;
        logic        do_pr;
        rd_exp_t     re;
        pr_exp_t     pe;
        logic [31:0] act;
        do_rd = srd && sb_rd;
        do_pr = probe;
        if (do_rd || do_pr) begin
            #1;
            if (do_rd) begin
                n_checks++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_queue_empty: got 0x%08h with nothing expected", sdata_out);
                end else begin
                    re = rd_q.pop_front();
                    if (sdata_out !== re.exp) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%08h expected 0x%08h", re.name, sdata_out, re.exp);
                    end
                end
            end
            if (do_pr) begin
                n_checks++;
                if (pr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL probe_queue_empty at %0t", $time);
                end else begin
                    pe = pr_q.pop_front();
                    case (pe.kind)
                        K_GPIO:  act = gpio_out;
                        K_INSP:  act = gpio_in_s_insp;
                        default: act = 32'(to_flag);
                    endcase
                    if (act !== pe.exp) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%08h expected 0x%08h", pe.name, act, pe.exp);
                    end
                end
            end
        end
    end

    task automatic push_rd(input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.exp  = exp;
        e.name = name;
        rd_q.push_back(e);
    endtask

    task automatic push_pr(input int kind, input logic [31:0] exp, input string name);
        pr_exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        pr_q.push_back(e);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        saddress = a;
        sdata_in = d;
        swr      = 1'b1;
        @(negedge clk);
        swr      = 1'b0;
    endtask

    task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        saddress = a;
        srd      = 1'b1;
        sb_rd    = 1'b1;
        push_rd(exp, name);
        @(negedge clk);
        srd      = 1'b0;
        sb_rd    = 1'b0;
    endtask

    task automatic probe_chk(input int kind, input logic [31:0] exp, input string name);
        @(negedge clk);
        probe = 1'b1;
        push_pr(kind, exp, name);
        @(negedge clk);
        probe = 1'b0;
    endtask

    // Bounded poll of the status register; an expired bound is scored as a failure
    task automatic wait_ready(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            saddress = A_START;
            srd      = 1'b1;
            @(negedge clk);
            srd      = 1'b0;
            got      = sdata_out[1];
        end
        to_flag = !got;
        probe_chk(K_TOUT, 32'h0, {tag, "_ready_timeout"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        saddress   = '0;
        srd        = 1'b0;
        swr        = 1'b0;
        sdata_in   = '0;
        gpio_in    = '0;
        gpio_latch = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        rd_chk(A_START, 32'h3, "rst_status");
        rd_chk(A_PL,    32'h0, "rst_prod_lo");
        rd_chk(A_PH,    32'h0, "rst_prod_hi");
        rd_chk(A_ONES,  32'h0, "rst_ones");
        probe_chk(K_GPIO, 32'h0, "rst_gpio_out");
        probe_chk(K_INSP, 32'h0, "rst_insp");

        // 3 * 5 with exact completion timing
        bus_wr(A_A1, 32'd3);
        bus_wr(A_A2, 32'd5);
        bus_wr(A_START, 32'h0);
        repeat (71) @(negedge clk);
        probe = 1'b1;
        push_pr(K_GPIO, 32'h0, "t2_gpio_before_done");
        @(negedge clk);
        saddress = A_START;
        srd      = 1'b1;
        sb_rd    = 1'b1;
        push_rd(32'h1, "t2_status_n73_busy");
        push_pr(K_GPIO, 32'h1, "t2_gpio_at_done");
        @(negedge clk);
        probe = 1'b0;
        push_rd(32'h3, "t2_status_n74_ready");
        @(negedge clk);
        srd   = 1'b0;
        sb_rd = 1'b0;
        rd_chk(A_PL,   32'h0000000F, "t2_prod_lo");
        rd_chk(A_PH,   32'h0,        "t2_prod_hi");
        rd_chk(A_ONES, 32'd4,        "t2_ones");

        // Full-scale operands
        bus_wr(A_A1, 32'hFFFFFFFF);
        bus_wr(A_A2, 32'h00FFFFFF);
        bus_wr(A_START, 32'h0);
        wait_ready("t3");
        rd_chk(A_PL,    32'hFE000001, "t3_prod_lo");
        rd_chk(A_PH,    32'h0000FFFF, "t3_prod_hi");
        rd_chk(A_ONES,  32'd24,       "t3_ones");
        rd_chk(A_START, 32'h2,        "t3_status");
        probe_chk(K_GPIO, 32'd2, "t3_gpio_out");

        // Start and shadow write while busy
        bus_wr(A_A1, 32'd2);
        bus_wr(A_A2, 32'd3);
        bus_wr(A_START, 32'h0);
        repeat (8) @(negedge clk);
        bus_wr(A_START, 32'h0);
        repeat (8) @(negedge clk);
        bus_wr(A_A1, 32'd7);
        wait_ready("t4a");
        rd_chk(A_PL,    32'd6, "t4_prod_first");
        rd_chk(A_ONES,  32'd2, "t4_ones_first");
        rd_chk(A_START, 32'h3, "t4_status");
        probe_chk(K_GPIO, 32'd3, "t4_gpio_once");
        bus_wr(A_START, 32'h0);
        wait_ready("t4b");
        rd_chk(A_PL,   32'd21, "t4_prod_new_a1");
        rd_chk(A_ONES, 32'd3,  "t4_ones_new_a1");
        probe_chk(K_GPIO, 32'd4, "t4_gpio_second");

        // Reset during MULT
        bus_wr(A_A1, 32'h123);
        bus_wr(A_A2, 32'h456);
        bus_wr(A_START, 32'h0);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_chk(A_START, 32'h3, "t5_status");
        rd_chk(A_PL,    32'h0, "t5_prod_lo");
        rd_chk(A_PH,    32'h0, "t5_prod_hi");
        rd_chk(A_ONES,  32'h0, "t5_ones");
        probe_chk(K_GPIO, 32'h0, "t5_gpio_out");
        bus_wr(A_A1, 32'd6);
        bus_wr(A_A2, 32'd7);
        bus_wr(A_START, 32'h0);
        wait_ready("t5");
        rd_chk(A_PL,   32'd42, "t5_prod_after");
        rd_chk(A_ONES, 32'd3,  "t5_ones_after");
        probe_chk(K_GPIO, 32'd1, "t5_gpio_after");

        // Counter wrap and GPIO capture
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        probe_chk(K_GPIO, 32'h0000FFFF, "t6_gpio_preload");
        bus_wr(A_A1, 32'd1);
        bus_wr(A_A2, 32'd1);
        bus_wr(A_START, 32'h0);
        wait_ready("t6");
        probe_chk(K_GPIO, 32'h0, "t6_gpio_wrap");
        rd_chk(A_PL,   32'd1, "t6_prod");
        rd_chk(A_ONES, 32'd1, "t6_ones");
        @(negedge clk);
        gpio_in    = 32'hA5A5A5A5;
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in    = 32'h12345678;
        probe_chk(K_INSP, 32'hA5A5A5A5, "t6_insp_latched");
        repeat (3) @(negedge clk);
        probe_chk(K_INSP, 32'hA5A5A5A5, "t6_insp_hold");

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
